// File: rtl/axi_slave_pkg.sv
// Shared AXI slave constants and FSM state type.
// Used by the SRAM responder and its interface.
package axi_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    READ,
    WRITE,
    WRESP
  } sram_slv_state_e;

endpackage

// File: rtl/sram_axi_slave_if.sv
// AXI4 slave-port bundle between a bus master and the SRAM responder.
// Only the channel signals the responder uses are carried.
interface sram_axi_slave_if #(
  parameter int ID_W  = 8,
  parameter int LEN_W = 4
);

  logic              ARVALID_S;
  logic              ARREADY_S;
  logic [31:0]       ARADDR_S;
  logic [ID_W-1:0]   ARID_S;
  logic [LEN_W-1:0]  ARLEN_S;
  logic [2:0]        ARSIZE_S;
  logic [1:0]        ARBURST_S;

  logic [ID_W-1:0]   RID_S;
  logic [31:0]       RDATA_S;
  logic [1:0]        RRESP_S;
  logic              RLAST_S;
  logic              RVALID_S;
  logic              RREADY_S;

  logic              AWVALID_S;
  logic              AWREADY_S;
  logic [31:0]       AWADDR_S;
  logic [ID_W-1:0]   AWID_S;
  logic [LEN_W-1:0]  AWLEN_S;
  logic [2:0]        AWSIZE_S;
  logic [1:0]        AWBURST_S;

  logic              WVALID_S;
  logic              WREADY_S;
  logic [31:0]       WDATA_S;
  logic [3:0]        WSTRB_S;
  logic              WLAST_S;

  logic [ID_W-1:0]   BID_S;
  logic [1:0]        BRESP_S;
  logic              BVALID_S;
  logic              BREADY_S;

  modport slave (
    input  ARVALID_S, ARADDR_S, ARID_S, ARLEN_S,
    input  ARSIZE_S, ARBURST_S,
    output ARREADY_S,
    output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    input  RREADY_S,
    input  AWVALID_S, AWADDR_S, AWID_S, AWLEN_S,
    input  AWSIZE_S, AWBURST_S,
    output AWREADY_S,
    input  WVALID_S, WDATA_S, WSTRB_S, WLAST_S,
    output WREADY_S,
    output BID_S, BRESP_S, BVALID_S,
    input  BREADY_S
  );

  modport master (
    output ARVALID_S, ARADDR_S, ARID_S, ARLEN_S,
    output ARSIZE_S, ARBURST_S,
    input  ARREADY_S,
    input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    output RREADY_S,
    output AWVALID_S, AWADDR_S, AWID_S, AWLEN_S,
    output AWSIZE_S, AWBURST_S,
    input  AWREADY_S,
    output WVALID_S, WDATA_S, WSTRB_S, WLAST_S,
    input  WREADY_S,
    input  BID_S, BRESP_S, BVALID_S,
    output BREADY_S
  );

endinterface

// File: rtl/sram_axi_slave.sv
// AXI4 INCR-burst responder in front of a single-port sync SRAM.
// One transaction at a time; AR/AW arbitrated round-robin.
module sram_axi_slave
  import axi_slave_pkg::*;
#(
  parameter int ID_W    = 8,
  parameter int LEN_W   = 4,
  parameter int SRAM_AW = 14
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  sram_axi_slave_if.slave    axi,
  output logic               CEB,
  output logic               WEB,
  output logic [31:0]        BWEB,
  output logic [SRAM_AW-1:0] A,
  output logic [31:0]        DI,
  input  logic [31:0]        DO
);

  sram_slv_state_e    state_q, state_d;
  logic               last_rd_q, last_rd_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic               err_q, err_d;

  logic               ar_win;
  logic               aw_win;
  logic               cnt_end;
  logic [SRAM_AW-1:0] addr_inc;
  logic               unused_bits;

  function automatic logic [31:0] strb2bweb(
    input logic [3:0] strb
  );
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{~strb[i]}};
    end
    return m;
  endfunction

  // The channel not served last wins a tie.
  assign ar_win = axi.ARVALID_S &
                  (~axi.AWVALID_S | ~last_rd_q);
  assign aw_win = axi.AWVALID_S &
                  (~axi.ARVALID_S | last_rd_q);

  assign cnt_end  = (cnt_q == len_q);
  assign addr_inc = addr_q + SRAM_AW'(1);

  assign axi.RID_S   = id_q;
  assign axi.RRESP_S = RESP_OKAY;
  assign axi.BID_S   = id_q;

  // Size/burst are assumed word/INCR; upper and byte address bits ignored.
  assign unused_bits = ^{axi.ARSIZE_S, axi.ARBURST_S,
                         axi.AWSIZE_S, axi.AWBURST_S,
                         axi.ARADDR_S[31:SRAM_AW+2],
                         axi.ARADDR_S[1:0],
                         axi.AWADDR_S[31:SRAM_AW+2],
                         axi.AWADDR_S[1:0]};

  // Transaction state registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      id_q      <= id_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
    end
  end

  // Next state plus bus and SRAM strobes.
  always_comb begin
    state_d       = state_q;
    last_rd_d     = last_rd_q;
    id_d          = id_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    err_d         = err_q;
    axi.ARREADY_S = 1'b0;
    axi.AWREADY_S = 1'b0;
    axi.WREADY_S  = 1'b0;
    axi.RVALID_S  = 1'b0;
    axi.RDATA_S   = '0;
    axi.RLAST_S   = 1'b0;
    axi.BVALID_S  = 1'b0;
    axi.BRESP_S   = RESP_OKAY;
    CEB           = 1'b1;
    WEB           = 1'b1;
    BWEB          = '1;
    A             = addr_q;
    DI            = '0;
    unique case (state_q)
      IDLE: begin
        axi.ARREADY_S = ~aw_win;
        axi.AWREADY_S = ~ar_win;
        if (ar_win) begin
          id_d      = axi.ARID_S;
          len_d     = axi.ARLEN_S;
          addr_d    = axi.ARADDR_S[SRAM_AW+1:2];
          cnt_d     = '0;
          last_rd_d = 1'b1;
          state_d   = RADDR;
        end else if (aw_win) begin
          id_d      = axi.AWID_S;
          len_d     = axi.AWLEN_S;
          addr_d    = axi.AWADDR_S[SRAM_AW+1:2];
          cnt_d     = '0;
          err_d     = 1'b0;
          last_rd_d = 1'b0;
          state_d   = WRITE;
        end
      end
      RADDR: begin
        CEB     = 1'b0;
        state_d = READ;
      end
      READ: begin
        axi.RVALID_S = 1'b1;
        axi.RDATA_S  = DO;
        axi.RLAST_S  = cnt_end;
        if (axi.RREADY_S) begin
          if (cnt_end) begin
            state_d = IDLE;
          end else begin
            CEB    = 1'b0;
            A      = addr_inc;
            addr_d = addr_inc;
            cnt_d  = cnt_q + LEN_W'(1);
          end
        end
      end
      WRITE: begin
        axi.WREADY_S = 1'b1;
        if (axi.WVALID_S) begin
          CEB    = 1'b0;
          WEB    = 1'b0;
          DI     = axi.WDATA_S;
          BWEB   = strb2bweb(axi.WSTRB_S);
          addr_d = addr_inc;
          cnt_d  = cnt_q + LEN_W'(1);
          if (axi.WLAST_S != cnt_end) begin
            err_d = 1'b1;
          end
          if (axi.WLAST_S || cnt_end) begin
            state_d = WRESP;
          end
        end
      end
      WRESP: begin
        axi.BVALID_S = 1'b1;
        axi.BRESP_S  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (axi.BREADY_S) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Directed bench for sram_axi_slave with a behavioural SRAM macro.
// Single-beat vectors from a table, multi-beat corners by hand.
module tb_sram_axi_slave;

  logic        clk;
  logic        rst_n;
  logic        ceb;
  logic        web;
  logic [31:0] bweb;
  logic [13:0] a;
  logic [31:0] di;
  logic [31:0] sram_do;

  logic [31:0] mem [16384];
  logic [31:0] wdat [16];
  logic [31:0] ex [16];

  int n_chk;
  int n_err;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [13];

  sram_axi_slave_if #(.ID_W(8), .LEN_W(4)) bus ();

  sram_axi_slave dut (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .axi     (bus.slave),
    .CEB     (ceb),
    .WEB     (web),
    .BWEB    (bweb),
    .A       (a),
    .DI      (di),
    .DO      (sram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ceb) begin
      if (!web) mem[a] <= (mem[a] & bweb) | (di & ~bweb);
      else      sram_do <= mem[a];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #1;
    chk({nm, " valids"},
        {bus.RVALID_S, bus.BVALID_S, bus.WREADY_S, bus.RLAST_S}, 0);
    chk({nm, " ceb/web"}, {ceb, web}, 2'b11);
    chk({nm, " bweb"}, bweb, 32'hFFFF_FFFF);
    chk({nm, " resp"}, {bus.RRESP_S, bus.BRESP_S}, 0);
    chk({nm, " rdata"}, bus.RDATA_S, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic ar_phase(input logic [31:0] addr, input int len,
                          input logic [7:0] id, input string nm);
    int n = 0;
    @(negedge clk);
    bus.ARVALID_S = 1'b1;
    bus.ARADDR_S  = addr;
    bus.ARLEN_S   = 4'(len);
    bus.ARID_S    = id;
    bus.ARSIZE_S  = 3'b010;
    bus.ARBURST_S = 2'b01;
    #1;
    while (!bus.ARREADY_S && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, " arready"}, bus.ARREADY_S, 1);
    @(posedge clk); #1;
    bus.ARVALID_S = 1'b0;
  endtask

  task automatic aw_phase(input logic [31:0] addr, input int len,
                          input logic [7:0] id, input string nm);
    int n = 0;
    @(negedge clk);
    bus.AWVALID_S = 1'b1;
    bus.AWADDR_S  = addr;
    bus.AWLEN_S   = 4'(len);
    bus.AWID_S    = id;
    bus.AWSIZE_S  = 3'b010;
    bus.AWBURST_S = 2'b01;
    #1;
    while (!bus.AWREADY_S && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, " awready"}, bus.AWREADY_S, 1);
    @(posedge clk); #1;
    bus.AWVALID_S = 1'b0;
  endtask

  task automatic finish_read(input int len, input logic [7:0] id,
                             input logic [3:0] pat, input string nm);
    int lat = 0, beat = 0, gaps = 0, guard = 0, p = 0;
    bit started = 0;
    while (beat <= len && guard < 200) begin
      @(negedge clk);
      guard++;
      if (!started) lat++;
      bus.RREADY_S = pat[p % 4];
      #1;
      if (bus.RVALID_S) begin
        if (!started) chk({nm, " latency"}, lat, 2);
        started = 1;
        chk($sformatf("%s data[%0d]", nm, beat), bus.RDATA_S, ex[beat]);
        chk($sformatf("%s rlast[%0d]", nm, beat), bus.RLAST_S, beat == len);
        if (bus.RREADY_S) begin
          if (beat == len) chk({nm, " rid"}, bus.RID_S, id);
          beat++;
        end else begin
          chk($sformatf("%s stall ceb[%0d]", nm, beat), ceb, 1);
        end
        p++;
      end else if (started) begin
        gaps++;
      end
    end
    chk({nm, " completed"}, beat > len, 1);
    if (pat == 4'hF) chk({nm, " gaps"}, gaps, 0);
    @(posedge clk); #1;
    bus.RREADY_S = 1'b0;
    chk({nm, " rvalid after last"}, bus.RVALID_S, 0);
  endtask

  task automatic finish_write(input logic [31:0] addr, input int nbeats,
                              input logic [3:0] strb, input logic [7:0] id,
                              input logic [1:0] exp_resp, input string nm);
    int n;
    logic [31:0] eb;
    logic [13:0] ea;
    eb = {{8{~strb[3]}}, {8{~strb[2]}}, {8{~strb[1]}}, {8{~strb[0]}}};
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      bus.WVALID_S = 1'b1;
      bus.WDATA_S  = wdat[b];
      bus.WSTRB_S  = strb;
      bus.WLAST_S  = (b == nbeats - 1);
      #1;
      n = 0;
      while (!bus.WREADY_S && n < 20) begin
        @(negedge clk); #1; n++;
      end
      ea = 14'((addr >> 2) + 32'(b));
      chk($sformatf("%s wready[%0d]", nm, b), bus.WREADY_S, 1);
      chk($sformatf("%s ceb/web[%0d]", nm, b), {ceb, web}, 0);
      chk($sformatf("%s A[%0d]", nm, b), a, ea);
      chk($sformatf("%s DI[%0d]", nm, b), di, wdat[b]);
      chk($sformatf("%s BWEB[%0d]", nm, b), bweb, eb);
    end
    @(negedge clk);
    bus.WVALID_S = 1'b0;
    bus.WLAST_S  = 1'b0;
    #1;
    chk({nm, " bvalid next cycle"}, bus.BVALID_S, 1);
    chk({nm, " wready in resp"}, bus.WREADY_S, 0);
    n = 0;
    while (!bus.BVALID_S && n < 20) begin
      @(negedge clk); #1; n++;
    end
    bus.BREADY_S = 1'b1;
    chk({nm, " bresp"}, bus.BRESP_S, exp_resp);
    chk({nm, " bid"}, bus.BID_S, id);
    @(posedge clk); #1;
    bus.BREADY_S = 1'b0;
    chk({nm, " bvalid after b"}, bus.BVALID_S, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] id;
    string nm;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b1;
    bus.ARVALID_S = 0; bus.ARADDR_S = 0; bus.ARID_S = 0;
    bus.ARLEN_S = 0; bus.ARSIZE_S = 0; bus.ARBURST_S = 0;
    bus.AWVALID_S = 0; bus.AWADDR_S = 0; bus.AWID_S = 0;
    bus.AWLEN_S = 0; bus.AWSIZE_S = 0; bus.AWBURST_S = 0;
    bus.WVALID_S = 0; bus.WDATA_S = 0; bus.WSTRB_S = 0;
    bus.WLAST_S = 0; bus.RREADY_S = 0; bus.BREADY_S = 0;

    vt[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vt[1]  = '{1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'hDEAD_BEEF};
    vt[2]  = '{1'b0, 32'h0000_0043, 32'h0, 4'h0, 32'hDEAD_BEEF};
    vt[3]  = '{1'b0, 32'h0001_0040, 32'h0, 4'h0, 32'hDEAD_BEEF};
    vt[4]  = '{1'b1, 32'h0000_0200, 32'h1122_3344, 4'hF, 32'h0};
    vt[5]  = '{1'b1, 32'h0000_0200, 32'hAABB_CCDD, 4'h5, 32'h0};
    vt[6]  = '{1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'h11BB_33DD};
    vt[7]  = '{1'b1, 32'h0000_0204, 32'h0, 4'hF, 32'h0};
    vt[8]  = '{1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4'hA, 32'h0};
    vt[9]  = '{1'b0, 32'h0000_0204, 32'h0, 4'h0, 32'hCA00_F000};
    vt[10] = '{1'b1, 32'h0000_0208, 32'h0, 4'hF, 32'h0};
    vt[11] = '{1'b1, 32'h0000_0208, 32'h1234_5678, 4'h0, 32'h0};
    vt[12] = '{1'b0, 32'h0000_0208, 32'h0, 4'h0, 32'h0};

    @(negedge clk);
    do_reset("reset");

    for (int i = 0; i < 13; i++) begin
      id = 8'(8'h10 + i);
      nm = $sformatf("vec%0d", i);
      if (vt[i].wr) begin
        wdat[0] = vt[i].data;
        aw_phase(vt[i].addr, 0, id, nm);
        finish_write(vt[i].addr, 1, vt[i].strb, id, 2'b00, nm);
      end else begin
        ex[0] = vt[i].exp;
        ar_phase(vt[i].addr, 0, id, nm);
        finish_read(0, id, 4'hF, nm);
      end
    end

    for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
    aw_phase(32'h100, 3, 8'h31, "wr4");
    finish_write(32'h100, 4, 4'hF, 8'h31, 2'b00, "wr4");
    for (int i = 0; i < 4; i++) ex[i] = 32'(i + 1);
    ar_phase(32'h100, 3, 8'h32, "rd4");
    finish_read(3, 8'h32, 4'hF, "rd4");

    for (int i = 0; i < 8; i++) wdat[i] = 32'hA0A0_0000 + 32'(i);
    aw_phase(32'h400, 7, 8'h33, "wr8");
    finish_write(32'h400, 8, 4'hF, 8'h33, 2'b00, "wr8");
    for (int i = 0; i < 8; i++) ex[i] = 32'hA0A0_0000 + 32'(i);
    ar_phase(32'h400, 7, 8'h34, "rd8 stall");
    finish_read(7, 8'h34, 4'b1001, "rd8 stall");

    wdat[0] = 32'h5A5A_5A5A;
    aw_phase(32'h4, 0, 8'h40, "sentinel");
    finish_write(32'h4, 1, 4'hF, 8'h40, 2'b00, "sentinel");
    wdat[0] = 32'h7777_0001;
    wdat[1] = 32'h7777_0002;
    aw_phase(32'hFFFC, 3, 8'h41, "early wlast");
    finish_write(32'hFFFC, 2, 4'hF, 8'h41, 2'b10, "early wlast");
    wdat[0] = 32'h0BAD_0BAD;
    aw_phase(32'h8, 0, 8'h42, "after err");
    finish_write(32'h8, 1, 4'hF, 8'h42, 2'b00, "after err");
    ex[0] = 32'h7777_0001;
    ex[1] = 32'h7777_0002;
    ex[2] = 32'h5A5A_5A5A;
    ar_phase(32'hFFFC, 2, 8'h43, "wrap rd");
    finish_read(2, 8'h43, 4'hF, "wrap rd");

    ar_phase(32'h100, 3, 8'h44, "abort");
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort rvalid before reset", bus.RVALID_S, 1);
    do_reset("mid-burst reset");

    @(negedge clk);
    bus.ARVALID_S = 1'b1; bus.ARADDR_S = 32'h40;
    bus.ARLEN_S = 0; bus.ARID_S = 8'h51;
    bus.AWVALID_S = 1'b1; bus.AWADDR_S = 32'h300;
    bus.AWLEN_S = 0; bus.AWID_S = 8'h52;
    #1;
    chk("arb1 arready", bus.ARREADY_S, 1);
    chk("arb1 awready", bus.AWREADY_S, 0);
    @(posedge clk); #1;
    bus.ARVALID_S = 1'b0;
    ex[0] = 32'hDEAD_BEEF;
    finish_read(0, 8'h51, 4'hF, "arb1 rd");

    @(negedge clk);
    bus.ARVALID_S = 1'b1; bus.ARID_S = 8'h53;
    #1;
    chk("arb2 awready", bus.AWREADY_S, 1);
    chk("arb2 arready", bus.ARREADY_S, 0);
    @(posedge clk); #1;
    bus.AWVALID_S = 1'b0;
    wdat[0] = 32'h3030_3030;
    finish_write(32'h300, 1, 4'hF, 8'h52, 2'b00, "arb2 wr");

    @(negedge clk); #1;
    chk("arb3 arready", bus.ARREADY_S, 1);
    @(posedge clk); #1;
    bus.ARVALID_S = 1'b0;
    finish_read(0, 8'h53, 4'hF, "arb3 rd");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
